// File: rtl/lidar_metadata_sequencer.sv
// Pairs each accepted bitstream word with its header length and hands the top metadata field downstream.
// Optional statistics counters are built only when LIDAR_META_STATS_EN is defined.
module lidar_metadata_sequencer #(
   parameter int WORD_W      = 512,
   parameter int META_W      = 128,
   parameter int HDR_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic [WORD_W-1:0] word_data,
   input  logic              hdr_valid,
   input  logic [7:0]        hdr_length,
   output logic              meta_valid,
   input  logic              meta_ready,
   output logic [META_W-1:0] meta_data,
   output logic [7:0]        meta_hdr_len,
   output logic              err_hdr_zero,
   output logic              err_timeout,
   output logic [15:0]       frame_count,
   output logic [15:0]       drop_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   localparam int              TMR_W   = (HDR_TIMEOUT > 2) ? $clog2(HDR_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HDR_TIMEOUT - 1);

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [TMR_W-1:0]  tmr_r;
   logic [TMR_W-1:0]  tmr_nxt_s;
   logic              capture_meta_s;
   logic              capture_hdr_s;
   logic              zero_err_s;
   logic              timeout_err_s;
   logic              frame_inc_s;
   logic              drop_inc_s;

   logic              word_ready_r;
   logic              meta_valid_r;
   logic [META_W-1:0] meta_data_r;
   logic [7:0]        meta_hdr_len_r;
   logic              err_hdr_zero_r;
   logic              err_timeout_r;

   // Only the metadata field of the word is consumed.
   logic unused_word_bits;
   assign unused_word_bits = ^word_data[WORD_W-META_W-1:0];

   // Next-state and event decode for the capture FSM.
   always_comb begin
      state_nxt_s    = state_r;
      tmr_nxt_s      = tmr_r;
      capture_meta_s = 1'b0;
      capture_hdr_s  = 1'b0;
      zero_err_s     = 1'b0;
      timeout_err_s  = 1'b0;
      frame_inc_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (word_valid) begin
               capture_meta_s = 1'b1;
               if (hdr_valid) begin
                  if (hdr_length == 8'd0) begin
                     zero_err_s  = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end else begin
                     capture_hdr_s = 1'b1;
                     state_nxt_s   = ST_OUT;
                  end
               end else begin
                  tmr_nxt_s   = {TMR_W{1'b0}};
                  state_nxt_s = ST_WAIT;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            tmr_nxt_s = tmr_r + TMR_W'(1);
            // A header arriving on the final allowed cycle still wins.
            if (hdr_valid) begin
               if (hdr_length == 8'd0) begin
                  zero_err_s  = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  capture_hdr_s = 1'b1;
                  state_nxt_s   = ST_OUT;
               end
            end else if (tmr_r == TMR_LAST) begin
               timeout_err_s = 1'b1;
               state_nxt_s   = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_OUT: begin
            if (meta_ready) begin
               frame_inc_s = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign drop_inc_s = zero_err_s | timeout_err_s;

   // State, timer and registered outputs; handshake flags are decoded from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         tmr_r          <= {TMR_W{1'b0}};
         word_ready_r   <= 1'b1;
         meta_valid_r   <= 1'b0;
         meta_data_r    <= {META_W{1'b0}};
         meta_hdr_len_r <= 8'd0;
         err_hdr_zero_r <= 1'b0;
         err_timeout_r  <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         tmr_r          <= tmr_nxt_s;
         word_ready_r   <= (state_nxt_s == ST_IDLE);
         meta_valid_r   <= (state_nxt_s == ST_OUT);
         err_hdr_zero_r <= zero_err_s;
         err_timeout_r  <= timeout_err_s;
         if (capture_meta_s) begin
            meta_data_r <= word_data[WORD_W-1 -: META_W];
         end
         if (capture_hdr_s) begin
            meta_hdr_len_r <= hdr_length;
         end
      end
   end

   assign word_ready   = word_ready_r;
   assign meta_valid   = meta_valid_r;
   assign meta_data    = meta_data_r;
   assign meta_hdr_len = meta_hdr_len_r;
   assign err_hdr_zero = err_hdr_zero_r;
   assign err_timeout  = err_timeout_r;

`ifdef LIDAR_META_STATS_EN
   logic [15:0] frame_count_r;
   logic [15:0] drop_count_r;

   // Handshake and drop counters, modulo 2^16.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_count_r <= 16'd0;
         drop_count_r  <= 16'd0;
      end else begin
         if (frame_inc_s) begin
            frame_count_r <= frame_count_r + 16'd1;
         end
         if (drop_inc_s) begin
            drop_count_r <= drop_count_r + 16'd1;
         end
      end
   end

   assign frame_count = frame_count_r;
   assign drop_count  = drop_count_r;
`else
   logic unused_stats;
   assign unused_stats = frame_inc_s ^ drop_inc_s;
   assign frame_count  = 16'h0000;
   assign drop_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_lidar_metadata_sequencer.sv
// Self-checking bench for lidar_metadata_sequencer: directed cases plus randomized transactions
// checked against a transaction-level timing model.
module tb_lidar_metadata_sequencer;

   localparam int TO = 16;

   logic         clk;
   logic         rst_n;
   logic         word_valid;
   logic         word_ready;
   logic [511:0] word_data;
   logic         hdr_valid;
   logic [7:0]   hdr_length;
   logic         meta_valid;
   logic         meta_ready;
   logic [127:0] meta_data;
   logic [7:0]   meta_hdr_len;
   logic         err_hdr_zero;
   logic         err_timeout;
   logic [15:0]  frame_count;
   logic [15:0]  drop_count;

   int checks = 0;
   int errors = 0;
   int frames = 0;
   int drops  = 0;

   lidar_metadata_sequencer #(.WORD_W(512), .META_W(128), .HDR_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
      .hdr_valid(hdr_valid), .hdr_length(hdr_length),
      .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_data(meta_data),
      .meta_hdr_len(meta_hdr_len), .err_hdr_zero(err_hdr_zero), .err_timeout(err_timeout),
      .frame_count(frame_count), .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counters only exist in the statistics build; otherwise they must read zero.
   function automatic logic [15:0] exp_cnt(input int v);
`ifdef LIDAR_META_STATS_EN
      return 16'(v);
`else
      return 16'h0000;
`endif
   endfunction

   function automatic logic [511:0] rand_word(input logic [127:0] m);
      logic [511:0] w;
      for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
      w[511:384] = m;
      return w;
   endfunction

   function automatic logic [127:0] rand_meta();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Idle cycles with stray headers that must be ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         word_valid = 1'b0;
         hdr_valid  = 1'($urandom_range(0, 1));
         hdr_length = 8'($urandom);
         @(negedge clk);
         chk("idle_ready", word_ready, 1'b1);
         chk("idle_meta_valid", meta_valid, 1'b0);
         chk("idle_errs", {err_hdr_zero, err_timeout}, 2'b00);
      end
      hdr_valid = 1'b0;
   endtask

   // One word: header d cycles after acceptance (d > TO means never), metadata held for 'hold' cycles.
   // Called on a negedge where the DUT is idle; returns on a negedge where it is idle again.
   task automatic run_txn(input logic [127:0] m, input logic [7:0] len, input int d, input int hold);
      int last;
      chk("accept_ready", word_ready, 1'b1);
      word_valid = 1'b1;
      word_data  = rand_word(m);
      hdr_valid  = (d == 0);
      hdr_length = (d == 0) ? len : 8'($urandom);
      last = (d <= TO) ? d : TO;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         chk("wait_ready", word_ready, 1'b0);
         chk("wait_meta_valid", meta_valid, 1'b0);
         chk("wait_errs", {err_hdr_zero, err_timeout}, 2'b00);
         word_valid = 1'($urandom_range(0, 1));
         word_data  = rand_word(~m);
         hdr_valid  = (k == d);
         hdr_length = (k == d) ? len : 8'($urandom);
      end
      @(negedge clk);
      word_valid = 1'b0;
      hdr_valid  = 1'b0;
      if (d > TO || len == 8'd0) begin
         drops++;
         chk("err_timeout", err_timeout, (d > TO));
         chk("err_hdr_zero", err_hdr_zero, (d <= TO));
         chk("err_meta_valid", meta_valid, 1'b0);
         chk("err_ready", word_ready, 1'b1);
         chk("drop_count", drop_count, exp_cnt(drops));
         @(negedge clk);
         chk("err_pulse_end", {err_hdr_zero, err_timeout}, 2'b00);
         chk("err_after_ready", word_ready, 1'b1);
         chk("err_after_meta", meta_valid, 1'b0);
      end else begin
         chk("out_meta_valid", meta_valid, 1'b1);
         chk("out_meta_data", meta_data, m);
         chk("out_hdr_len", meta_hdr_len, len);
         chk("out_ready", word_ready, 1'b0);
         chk("out_errs", {err_hdr_zero, err_timeout}, 2'b00);
         for (int h = 0; h < hold; h++) begin
            meta_ready = 1'b0;
            word_valid = 1'($urandom_range(0, 1));
            word_data  = rand_word(~m);
            hdr_valid  = 1'($urandom_range(0, 1));
            hdr_length = 8'($urandom);
            @(negedge clk);
            chk("hold_meta_valid", meta_valid, 1'b1);
            chk("hold_meta_data", meta_data, m);
            chk("hold_hdr_len", meta_hdr_len, len);
            chk("hold_ready", word_ready, 1'b0);
         end
         meta_ready = 1'b1;
         word_valid = 1'b0;
         hdr_valid  = 1'b0;
         @(negedge clk);
         meta_ready = 1'b0;
         frames++;
         chk("hs_meta_valid", meta_valid, 1'b0);
         chk("hs_ready", word_ready, 1'b1);
         chk("frame_count", frame_count, exp_cnt(frames));
         chk("drop_count_hs", drop_count, exp_cnt(drops));
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      hdr_valid  = 1'b0;
      hdr_length = 8'd0;
      meta_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", word_ready, 1'b1);
      chk("rst_meta_valid", meta_valid, 1'b0);
      chk("rst_meta_data", meta_data, 128'd0);
      chk("rst_hdr_len", meta_hdr_len, 8'd0);
      chk("rst_errs", {err_hdr_zero, err_timeout}, 2'b00);
      chk("rst_frames", frame_count, 16'd0);
      chk("rst_drops", drop_count, 16'd0);
      rst_n = 1'b1;

      run_txn({16{8'hA5}}, 8'd40, 0, 0);
      run_txn(rand_meta(), 8'd100, 3, 0);
      run_txn(rand_meta(), 8'd0, 2, 0);
      run_txn(rand_meta(), 8'd0, 0, 0);
      run_txn(rand_meta(), 8'd9, TO + 1, 0);
      run_txn(rand_meta(), 8'd7, TO, 1);
      run_txn(rand_meta(), 8'd255, 1, 10);
      idle(3);
      // Back-to-back words at the two-cycle rate.
      for (int i = 0; i < 4; i++) run_txn(rand_meta(), 8'(i + 1), 0, 0);

      for (int i = 0; i < 200; i++) begin
         logic [7:0] len;
         int         d;
         len = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         d   = ($urandom_range(0, 5) == 0) ? TO + 1 + $urandom_range(0, 3) : $urandom_range(0, TO);
         run_txn(rand_meta(), len, d, $urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end

      // Reset while metadata is held.
      word_valid = 1'b1;
      word_data  = rand_word(rand_meta());
      hdr_valid  = 1'b1;
      hdr_length = 8'd50;
      @(negedge clk);
      word_valid = 1'b0;
      hdr_valid  = 1'b0;
      chk("pre_rst_meta_valid", meta_valid, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      frames = 0;
      drops  = 0;
      chk("midrst_meta_valid", meta_valid, 1'b0);
      chk("midrst_ready", word_ready, 1'b1);
      chk("midrst_meta_data", meta_data, 128'd0);
      chk("midrst_hdr_len", meta_hdr_len, 8'd0);
      chk("midrst_frames", frame_count, 16'd0);
      chk("midrst_drops", drop_count, 16'd0);
      rst_n = 1'b1;
      run_txn(rand_meta(), 8'd33, 2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
